// File: rtl/bits_pkg.sv
// Shared definitions for the bit-decoder correlator and the parent bit detector:
// symbol slot indices, the per-bank window-length table and width helpers.
package bits_pkg;

    // Slot index of each symbol template inside corr_dat
    localparam int SYM_S1 = 0;   // constant high (data 1)
    localparam int SYM_S2 = 1;   // high->low mid-bit (data 0)
    localparam int SYM_S3 = 2;   // low->high mid-bit (data 0)
    localparam int SYM_S4 = 3;   // constant low (data 1)
    localparam int NUM_SYMS = 4;

    // Window length for a bank: max(2, length - 2*bank), rounded down to even.
    // The bit detector uses the same table for its bit-period lengths.
    function automatic int corr_len(input int bank, input int length);
        int len;
        len = length - 2 * bank;
        if (len < 2) len = 2;
        len = len & ~1;
        return len;
    endfunction

    // Width able to hold a count in 0..length
    function automatic int corr_width(input int length);
        return $clog2(length + 1);
    endfunction

    // Width of the bank select for a given bank count
    function automatic int bank_width(input int banks);
        return $clog2(banks);
    endfunction

endpackage

// File: rtl/bits_popcount.sv
// Masked ones-count: counts set bits of vec whose index lies in [lo, hi).
module bits_popcount #(
    parameter int LENGTH     = 4,
    parameter int CORR_WIDTH = 3
) (
    input  logic [LENGTH-1:0]     vec,
    input  logic [CORR_WIDTH-1:0] lo,
    input  logic [CORR_WIDTH-1:0] hi,
    output logic [CORR_WIDTH-1:0] count
);

    // Accumulate set bits inside the index window
    always_comb begin
        count = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (CORR_WIDTH'(i) >= lo && CORR_WIDTH'(i) < hi && vec[i]) begin
                count = count + CORR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/bits_correlator.sv
// Sliding-window matched-filter bank for FM0 backscatter decoding.
// Each accepted sample is shifted into a history register and four symbol
// template correlations over the newest L samples are registered together.
module bits_correlator
    import bits_pkg::*;
#(
    parameter  int LENGTH     = 4,
    parameter  int BANKS      = 4,
    localparam int CORR_WIDTH = corr_width(LENGTH),
    localparam int BANK_WIDTH = bank_width(BANKS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_dat,
    input  logic                           in_vld,
    input  logic [BANK_WIDTH-1:0]          frequency_bank,
    output logic [NUM_SYMS*CORR_WIDTH-1:0] corr_dat,
    output logic                           corr_vld
);

    logic [LENGTH-1:0]            hist;
    logic [LENGTH-1:0]            hist_next;
    logic [BANK_WIDTH-1:0]        bank_eff;
    logic [CORR_WIDTH-1:0]        len_tab [BANKS];
    logic [CORR_WIDTH-1:0]        win_len;
    logic [CORR_WIDTH-1:0]        half_len;
    logic [CORR_WIDTH-1:0]        ones_first;
    logic [CORR_WIDTH-1:0]        ones_second;
    logic [CORR_WIDTH-1:0]        s1;
    logic [CORR_WIDTH-1:0]        s2;
    logic [CORR_WIDTH-1:0]        s3;
    logic [CORR_WIDTH-1:0]        s4;
    logic [NUM_SYMS*CORR_WIDTH-1:0] corr_next;

    // History including the sample offered this cycle, so the result covers it
    assign hist_next = {hist[LENGTH-2:0], in_dat};

    // Out-of-range bank selects fall back to the last (shortest) bank
    always_comb begin
        if (int'(frequency_bank) >= BANKS) bank_eff = BANK_WIDTH'(BANKS - 1);
        else                               bank_eff = frequency_bank;
    end

    // Window-length table, constant per elaboration
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            len_tab[b] = CORR_WIDTH'(corr_len(b, LENGTH));
        end
    end

    assign win_len  = len_tab[bank_eff];
    assign half_len = win_len >> 1;

    // Older half of the window: hist[L-1:H]
    bits_popcount #(
        .LENGTH     (LENGTH),
        .CORR_WIDTH (CORR_WIDTH)
    ) u_pop_first (
        .vec   (hist_next),
        .lo    (half_len),
        .hi    (win_len),
        .count (ones_first)
    );

    // Newer half of the window: hist[H-1:0]
    bits_popcount #(
        .LENGTH     (LENGTH),
        .CORR_WIDTH (CORR_WIDTH)
    ) u_pop_second (
        .vec   (hist_next),
        .lo    ('0),
        .hi    (half_len),
        .count (ones_second)
    );

    // Template scores; every term is bounded by L so no overflow occurs
    always_comb begin
        s1 = ones_first + ones_second;
        s2 = ones_first + (half_len - ones_second);
        s3 = win_len - s2;
        s4 = win_len - s1;
        corr_next = '0;
        corr_next[SYM_S1*CORR_WIDTH +: CORR_WIDTH] = s1;
        corr_next[SYM_S2*CORR_WIDTH +: CORR_WIDTH] = s2;
        corr_next[SYM_S3*CORR_WIDTH +: CORR_WIDTH] = s3;
        corr_next[SYM_S4*CORR_WIDTH +: CORR_WIDTH] = s4;
    end

    // Shift history and register the correlations on each accepted sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist     <= '0;
            corr_dat <= '0;
            corr_vld <= 1'b0;
        end else begin
            corr_vld <= in_vld;
            if (in_vld) begin
                hist     <= hist_next;
                corr_dat <= corr_next;
            end
        end
    end

endmodule

// File: tb/tb_bits_correlator.sv
module tb_bits_correlator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_dat = 1'b0;
    logic        in_vld = 1'b0;
    logic [1:0]  bank_a = 2'd0;
    logic [1:0]  bank_b = 2'd0;
    logic [11:0] corr_dat_a, corr_dat_b;
    logic        corr_vld_a, corr_vld_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ha = '0;
    logic [7:0]  hb = '0;
    logic [11:0] last_a = '0;
    logic [11:0] last_b = '0;
    logic [11:0] qa [$];
    logic [11:0] qb [$];

    always #5 clk = ~clk;

    // Default configuration: LENGTH=4, BANKS=4 -> lengths 4,2,2,2
    bits_correlator u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .in_dat         (in_dat),
        .in_vld         (in_vld),
        .frequency_bank (bank_a),
        .corr_dat       (corr_dat_a),
        .corr_vld       (corr_vld_a)
    );

    // LENGTH=6, BANKS=3 -> lengths 6,4,2; bank 3 is out of range and clamps to 2
    bits_correlator #(.LENGTH(6), .BANKS(3)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .in_dat         (in_dat),
        .in_vld         (in_vld),
        .frequency_bank (bank_b),
        .corr_dat       (corr_dat_b),
        .corr_vld       (corr_vld_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_a(input int b);
        case (b)
            0:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int len_b(input int b);
        case (b)
            0:       return 6;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    // Reference correlator from the template definitions
    function automatic logic [11:0] model(input logic [7:0] h, input int l);
        int o1, o2, s1, s2, s3, s4;
        o1 = 0;
        o2 = 0;
        for (int i = 0; i < l; i++) begin
            if (i >= l / 2) o1 += int'(h[i]);
            else            o2 += int'(h[i]);
        end
        s1 = o1 + o2;
        s2 = o1 + (l / 2 - o2);
        s3 = l - s2;
        s4 = l - s1;
        return {3'(s4), 3'(s3), 3'(s2), 3'(s1)};
    endfunction

    task automatic cycle(input logic d, input logic v);
        logic [11:0] e;
        in_dat = d;
        in_vld = v;
        if (v) begin
            ha = {ha[6:0], d};
            hb = {hb[6:0], d};
            qa.push_back(model(ha, len_a(int'(bank_a))));
            qb.push_back(model(hb, len_b(int'(bank_b))));
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        check_val("vld_a", 32'(corr_vld_a), 32'(v));
        check_val("vld_b", 32'(corr_vld_b), 32'(v));
        if (corr_vld_a) begin
            if (qa.size() == 0) check_val("sb_a_empty", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                check_val("dat_a", 32'(corr_dat_a), 32'(e));
                last_a = e;
            end
        end else begin
            check_val("hold_a", 32'(corr_dat_a), 32'(last_a));
        end
        if (corr_vld_b) begin
            if (qb.size() == 0) check_val("sb_b_empty", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                check_val("dat_b", 32'(corr_dat_b), 32'(e));
                last_b = e;
            end
        end else begin
            check_val("hold_b", 32'(corr_dat_b), 32'(last_b));
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check_val("rst_dat_a", 32'(corr_dat_a), 32'd0);
        check_val("rst_vld_a", 32'(corr_vld_a), 32'd0);
        check_val("rst_dat_b", 32'(corr_dat_b), 32'd0);
        check_val("rst_vld_b", 32'(corr_vld_b), 32'd0);
        ha = '0;
        hb = '0;
        last_a = '0;
        last_b = '0;
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        apply_reset();
        @(negedge clk);

        // Full window of ones at L=4
        bank_a = 2'd0;
        bank_b = 2'd1;
        foreach (ha[i]) if (i < 4) cycle(1'b1, 1'b1);
        check_val("t1_const", 32'(corr_dat_a), 32'({3'd0, 3'd2, 3'd2, 3'd4}));

        // High->low then low->high mid-bit templates
        cycle(1'b1, 1'b1); cycle(1'b1, 1'b1); cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
        check_val("t2_hl", 32'(corr_dat_a), 32'({3'd2, 3'd0, 3'd4, 3'd2}));
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b1, 1'b1); cycle(1'b1, 1'b1);
        check_val("t2_lh", 32'(corr_dat_a), 32'({3'd2, 3'd4, 3'd0, 3'd2}));

        // L=2 with ones parked above the window
        bank_a = 2'd1;
        bank_b = 2'd2;
        cycle(1'b1, 1'b1); cycle(1'b1, 1'b1); cycle(1'b0, 1'b1); cycle(1'b1, 1'b1);
        check_val("t3_l2", 32'(corr_dat_a), 32'({3'd1, 3'd2, 3'd0, 3'd1}));

        // Valid pattern with gaps; hold checked in the gaps
        bank_a = 2'd0;
        bank_b = 2'd0;
        cycle(1'b1, 1'b1); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1); cycle(1'b1, 1'b1); cycle(1'b0, 1'b0);

        // Reset mid-stream, then a single one at L=4
        cycle(1'b1, 1'b1);
        apply_reset();
        cycle(1'b1, 1'b1);
        check_val("t5_post_rst", 32'(corr_dat_a), 32'({3'd3, 3'd3, 3'd1, 3'd1}));

        // Random streams over every bank, including bank changes mid-stream
        for (int b = 0; b < 4; b++) begin
            bank_a = 2'(b);
            bank_b = 2'(b);
            for (int k = 0; k < 120; k++) begin
                if (k == 60) bank_b = 2'(3 - b);
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            end
        end

        check_val("sb_a_left", 32'(qa.size()), 32'd0);
        check_val("sb_b_left", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
